// File: rtl/riscv_pkg.sv
// Shared load/store encodings: funct3 access sizes, LSU FSM states and the
// alignment rule used to reject an access before it reaches memory.
package riscv_pkg;

    localparam int LSU_W = 32;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } lsu_state_e;

    // Unknown sizes are rejected the same way as misaligned ones.
    function automatic logic ls_fault(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        case (f3)
            LS_B, LS_BU: bad = 1'b0;
            LS_H, LS_HU: bad = off[0];
            LS_W:        bad = (off != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store strobes/replicated data on the
// request side, byte/half extraction with sign or zero extension on the load side.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]       st_off,
    input  logic [2:0]       st_size,
    input  logic [LSU_W-1:0] st_data,
    output logic [3:0]       st_strb,
    output logic [LSU_W-1:0] st_lane,
    input  logic [1:0]       ld_off,
    input  logic [2:0]       ld_size,
    input  logic [LSU_W-1:0] ld_word,
    output logic [LSU_W-1:0] ld_ext
);

    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    // Store side: strobe from offset, data replicated into every lane.
    always_comb begin
        st_strb = 4'b0000;
        st_lane = {LSU_W{1'b0}};
        case (st_size)
            LS_B, LS_BU: begin
                st_strb = 4'b0001 << st_off;
                st_lane = {4{st_data[7:0]}};
            end
            LS_H, LS_HU: begin
                st_strb = 4'b0011 << st_off;
                st_lane = {2{st_data[15:0]}};
            end
            LS_W: begin
                st_strb = 4'b1111;
                st_lane = st_data;
            end
            default: begin
                st_strb = 4'b0000;
                st_lane = {LSU_W{1'b0}};
            end
        endcase
    end

    // Load side: pick the addressed lane, then extend to full width.
    always_comb begin
        case (ld_off)
            2'b00:   ld_byte_s = ld_word[7:0];
            2'b01:   ld_byte_s = ld_word[15:8];
            2'b10:   ld_byte_s = ld_word[23:16];
            2'b11:   ld_byte_s = ld_word[31:24];
            default: ld_byte_s = 8'h00;
        endcase
        if (ld_off[1]) begin
            ld_half_s = ld_word[31:16];
        end else begin
            ld_half_s = ld_word[15:0];
        end
        case (ld_size)
            LS_B:    ld_ext = {{24{ld_byte_s[7]}}, ld_byte_s};
            LS_BU:   ld_ext = {24'h000000, ld_byte_s};
            LS_H:    ld_ext = {{16{ld_half_s[15]}}, ld_half_s};
            LS_HU:   ld_ext = {16'h0000, ld_half_s};
            LS_W:    ld_ext = ld_word;
            default: ld_ext = {LSU_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-access data-memory LSU: accepts a load/store in IDLE, holds mem_req
// until mem_ready or timeout, and returns the extended load result.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd_en,
    input  logic            wr_en,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic [2:0]      funct3,
    output logic            stall,
    output logic            ld_valid,
    output logic [XLEN-1:0] ld_data,
    output logic            fault_mis,
    output logic            fault_bus,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT);

    lsu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]      off_q, off_d;
    logic [2:0]      size_q, size_d;
    logic            ld_valid_q, ld_valid_d;
    logic [XLEN-1:0] ld_data_q, ld_data_d;
    logic            fault_mis_q, fault_mis_d;
    logic            fault_bus_q, fault_bus_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]      mem_wstrb_q, mem_wstrb_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;

    logic [3:0]      st_strb_s;
    logic [XLEN-1:0] st_lane_s;
    logic [XLEN-1:0] ld_ext_s;
    logic            req_s;

    assign req_s = rd_en | wr_en;

    lsu_align u_align (
        .st_off  (addr[1:0]),
        .st_size (funct3),
        .st_data (wdata),
        .st_strb (st_strb_s),
        .st_lane (st_lane_s),
        .ld_off  (off_q),
        .ld_size (size_q),
        .ld_word (mem_rdata),
        .ld_ext  (ld_ext_s)
    );

    // Next-state and next-output logic for the access FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        size_d      = size_q;
        ld_valid_d  = 1'b0;
        ld_data_d   = ld_data_q;
        fault_mis_d = 1'b0;
        fault_bus_d = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s && ls_fault(funct3, addr[1:0])) begin
                    fault_mis_d = 1'b1;
                end else if (req_s) begin
                    state_d     = ST_ACCESS;
                    cnt_d       = {CNT_W{1'b0}};
                    off_d       = addr[1:0];
                    size_d      = funct3;
                    mem_req_d   = 1'b1;
                    mem_we_d    = ~rd_en;
                    mem_addr_d  = {addr[XLEN-1:2], 2'b00};
                    // Loads never drive strobes or write data.
                    mem_wstrb_d = rd_en ? 4'b0000 : st_strb_s;
                    mem_wdata_d = rd_en ? {XLEN{1'b0}} : st_lane_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (mem_ready || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    state_d     = mem_ready ? ST_RESP : ST_IDLE;
                    fault_bus_d = ~mem_ready;
                    ld_valid_d  = mem_ready & ~mem_we_q;
                    ld_data_d   = (mem_ready && !mem_we_q) ? ld_ext_s : ld_data_q;
                    cnt_d       = {CNT_W{1'b0}};
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = {XLEN{1'b0}};
                    mem_wstrb_d = 4'b0000;
                    mem_wdata_d = {XLEN{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops mem_req immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            off_q       <= 2'b00;
            size_q      <= 3'b000;
            ld_valid_q  <= 1'b0;
            ld_data_q   <= {XLEN{1'b0}};
            fault_mis_q <= 1'b0;
            fault_bus_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {XLEN{1'b0}};
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= {XLEN{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            size_q      <= size_d;
            ld_valid_q  <= ld_valid_d;
            ld_data_q   <= ld_data_d;
            fault_mis_q <= fault_mis_d;
            fault_bus_q <= fault_bus_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Stall covers the accept cycle combinationally, then the whole ACCESS phase.
    assign stall     = (state_q == ST_ACCESS) || ((state_q == ST_IDLE) && req_s);
    assign ld_valid  = ld_valid_q;
    assign ld_data   = ld_data_q;
    assign fault_mis = fault_mis_q;
    assign fault_bus = fault_bus_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit: stores, loads, faults,
// bus timeout and reset in the middle of an access.
module tb_load_store_unit;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en, wr_en, mem_ready;
    logic [31:0] addr, wdata, mem_rdata;
    logic [2:0]  funct3;
    logic        stall, ld_valid, fault_mis, fault_bus, mem_req, mem_we;
    logic [31:0] ld_data, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    int errors = 0;
    int checks = 0;

    load_store_unit #(.XLEN(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst_n), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
        .wdata(wdata), .funct3(funct3), .stall(stall), .ld_valid(ld_valid),
        .ld_data(ld_data), .fault_mis(fault_mis), .fault_bus(fault_bus),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Runs one accepted access; mem_ready arrives after 'delay' idle ACCESS cycles.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] f,
                          input logic [31:0] rdata, input int delay,
                          output logic [3:0] strb, output logic [31:0] wd,
                          output logic [31:0] ma, output logic we, output int sc,
                          output logic lv, output logic [31:0] ld);
        sc = 0;
        rd_en = rd; wr_en = wr; addr = a; wdata = d; funct3 = f;
        #1;
        if (stall) sc++;
        cyc();
        rd_en = 1'b0; wr_en = 1'b0;
        #1;
        strb = mem_wstrb; wd = mem_wdata; ma = mem_addr; we = mem_we;
        for (int i = 0; i < delay; i++) begin
            if (stall) sc++;
            cyc();
        end
        mem_ready = 1'b1; mem_rdata = rdata;
        #1;
        if (stall) sc++;
        cyc();
        mem_ready = 1'b0; mem_rdata = 32'h0;
        #1;
        if (stall) sc++;
        lv = ld_valid; ld = ld_data;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = 32'h0; wdata = 32'h0;
        funct3 = 3'b000; mem_ready = 1'b0; mem_rdata = 32'h0;
        repeat (3) cyc();
        checks++; if ({stall, ld_valid, fault_mis, fault_bus, mem_req, mem_we} !== 6'b0) begin errors++; $display("FAIL reset_ctrl got=%b exp=000000", {stall, ld_valid, fault_mis, fault_bus, mem_req, mem_we}); end
        checks++; if ({ld_data, mem_addr, mem_wdata, mem_wstrb} !== 100'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", {ld_data, mem_addr, mem_wdata, mem_wstrb}); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_stores();
        logic [3:0] s; logic [31:0] wd, ma, ld; logic we, lv; int sc;
        access(1'b0, 1'b1, 32'h100, 32'h0003FFFF, 3'b010, 32'h0, 1, s, wd, ma, we, sc, lv, ld);
        checks++; if (s !== 4'hF) begin errors++; $display("FAIL sw_strb got=%h exp=f", s); end
        checks++; if (ma !== 32'h100) begin errors++; $display("FAIL sw_addr got=%h exp=100", ma); end
        checks++; if (wd !== 32'h0003FFFF) begin errors++; $display("FAIL sw_wdata got=%h exp=0003ffff", wd); end
        checks++; if (we !== 1'b1) begin errors++; $display("FAIL sw_we got=%b exp=1", we); end
        checks++; if (sc !== 3) begin errors++; $display("FAIL sw_stall got=%0d exp=3", sc); end
        checks++; if (lv !== 1'b0) begin errors++; $display("FAIL sw_ldvalid got=%b exp=0", lv); end
        access(1'b0, 1'b1, 32'h103, 32'h000000AB, 3'b000, 32'h0, 0, s, wd, ma, we, sc, lv, ld);
        checks++; if (s !== 4'h8) begin errors++; $display("FAIL sb_strb got=%h exp=8", s); end
        checks++; if (wd !== 32'hABABABAB) begin errors++; $display("FAIL sb_wdata got=%h exp=abababab", wd); end
        checks++; if (ma !== 32'h100) begin errors++; $display("FAIL sb_addr got=%h exp=100", ma); end
        checks++; if (sc !== 2) begin errors++; $display("FAIL sb_stall got=%0d exp=2", sc); end
        access(1'b0, 1'b1, 32'h102, 32'hFFFF1234, 3'b001, 32'h0, 0, s, wd, ma, we, sc, lv, ld);
        checks++; if (s !== 4'hC) begin errors++; $display("FAIL sh_strb got=%h exp=c", s); end
        checks++; if (wd !== 32'h12341234) begin errors++; $display("FAIL sh_wdata got=%h exp=12341234", wd); end
    endtask

    task automatic test_loads();
        logic [3:0] s; logic [31:0] wd, ma, ld; logic we, lv; int sc;
        access(1'b1, 1'b0, 32'h101, 32'h0, 3'b000, 32'h00008000, 0, s, wd, ma, we, sc, lv, ld);
        checks++; if (ld !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got=%h exp=ffffff80", ld); end
        checks++; if (lv !== 1'b1) begin errors++; $display("FAIL lb_valid got=%b exp=1", lv); end
        checks++; if ({we, s} !== 5'b0) begin errors++; $display("FAIL lb_we_strb got=%b exp=00000", {we, s}); end
        checks++; if (ma !== 32'h100) begin errors++; $display("FAIL lb_addr got=%h exp=100", ma); end
        checks++; if (ld_valid !== 1'b0) begin errors++; $display("FAIL lb_pulse got=%b exp=0", ld_valid); end
        access(1'b1, 1'b0, 32'h101, 32'h0, 3'b100, 32'h00008000, 0, s, wd, ma, we, sc, lv, ld);
        checks++; if (ld !== 32'h00000080) begin errors++; $display("FAIL lbu_data got=%h exp=00000080", ld); end
        access(1'b1, 1'b0, 32'h102, 32'h0, 3'b101, 32'hBEEF0000, 2, s, wd, ma, we, sc, lv, ld);
        checks++; if (ld !== 32'h0000BEEF) begin errors++; $display("FAIL lhu_data got=%h exp=0000beef", ld); end
        checks++; if (sc !== 4) begin errors++; $display("FAIL lhu_stall got=%0d exp=4", sc); end
        access(1'b1, 1'b0, 32'h102, 32'h0, 3'b001, 32'hBEEF0000, 0, s, wd, ma, we, sc, lv, ld);
        checks++; if (ld !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh_data got=%h exp=ffffbeef", ld); end
        access(1'b1, 1'b1, 32'h104, 32'h55555555, 3'b010, 32'hCAFEF00D, 0, s, wd, ma, we, sc, lv, ld);
        checks++; if (ld !== 32'hCAFEF00D) begin errors++; $display("FAIL lw_data got=%h exp=cafef00d", ld); end
        checks++; if ({we, s, wd} !== 37'h0) begin errors++; $display("FAIL rd_priority got=%b/%h/%h exp=0/0/0", we, s, wd); end
        checks++; if (ma !== 32'h104) begin errors++; $display("FAIL lw_addr got=%h exp=104", ma); end
        access(1'b0, 1'b1, 32'h108, 32'h1, 3'b010, 32'h0, 0, s, wd, ma, we, sc, lv, ld);
        checks++; if (ld !== 32'hCAFEF00D) begin errors++; $display("FAIL ld_hold got=%h exp=cafef00d", ld); end
    endtask

    task automatic test_misaligned();
        logic [2:0]  f3v [3] = '{3'b010, 3'b011, 3'b001};
        logic [31:0] av  [3] = '{32'h102, 32'h100, 32'h101};
        int req_seen;
        for (int k = 0; k < 3; k++) begin
            req_seen = 0;
            rd_en = (k != 2); wr_en = (k == 2); addr = av[k]; funct3 = f3v[k];
            #1;
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mis_stall%0d got=%b exp=1", k, stall); end
            cyc();
            rd_en = 1'b0; wr_en = 1'b0;
            #1;
            if (mem_req) req_seen++;
            checks++; if ({fault_mis, stall} !== 2'b10) begin errors++; $display("FAIL mis_pulse%0d got=%b exp=10", k, {fault_mis, stall}); end
            cyc();
            if (mem_req) req_seen++;
            checks++; if (fault_mis !== 1'b0) begin errors++; $display("FAIL mis_end%0d got=%b exp=0", k, fault_mis); end
            checks++; if (req_seen !== 0) begin errors++; $display("FAIL mis_noreq%0d got=%0d exp=0", k, req_seen); end
        end
    endtask

    task automatic test_timeout();
        int hit;
        hit = -1;
        rd_en = 1'b1; addr = 32'h200; funct3 = 3'b010;
        cyc();
        rd_en = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL tmo_req got=%b exp=1", mem_req); end
        for (int i = 1; i <= TMO + 4; i++) begin
            cyc();
            if (fault_bus && hit < 0) begin
                hit = i;
                checks++; if ({mem_req, stall} !== 2'b00) begin errors++; $display("FAIL tmo_drop got=%b exp=00", {mem_req, stall}); end
                checks++; if (ld_valid !== 1'b0) begin errors++; $display("FAIL tmo_ldvalid got=%b exp=0", ld_valid); end
            end
        end
        checks++; if (hit !== TMO) begin errors++; $display("FAIL tmo_cycles got=%0d exp=%0d", hit, TMO); end
        checks++; if (fault_bus !== 1'b0) begin errors++; $display("FAIL tmo_pulse got=%b exp=0", fault_bus); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] s; logic [31:0] wd, ma, ld; logic we, lv; int sc;
        wr_en = 1'b1; addr = 32'h30C; wdata = 32'hDEADBEEF; funct3 = 3'b010;
        cyc();
        wr_en = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmid_req got=%b exp=1", mem_req); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({stall, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, ld_data} !== 103'h0) begin errors++; $display("FAIL rmid_clear got=%b/%b/%h/%h exp=all zero", mem_req, mem_we, mem_wstrb, mem_addr); end
        mem_ready = 1'b1;
        cyc();
        rst_n = 1'b1;
        cyc();
        mem_ready = 1'b0;
        #1;
        checks++; if ({ld_valid, mem_req, stall} !== 3'b000) begin errors++; $display("FAIL rmid_late got=%b exp=000", {ld_valid, mem_req, stall}); end
        access(1'b1, 1'b0, 32'h300, 32'h0, 3'b010, 32'h11223344, 0, s, wd, ma, we, sc, lv, ld);
        checks++; if ({lv, ld} !== {1'b1, 32'h11223344}) begin errors++; $display("FAIL rmid_lw got=%b/%h exp=1/11223344", lv, ld); end
    endtask

    initial begin
        test_reset();
        test_stores();
        test_loads();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
